// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Whole core-clock cycles per serial bit.
  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_frame_sync.sv
// Multi-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_rx_frame_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing/overrun pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      serial_in,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic                      framing_error,
  output logic                      overrun,
  output logic                      parity_error
);

  localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int unsigned IDX_W            = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      pe_q, pe_d;
`endif

  uart_rx_frame_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (serial_in),
    .q    (rx_s)
  );

  // Next-state and output decode; every sample decision is taken on rx_s.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !data_out_ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^shift_q) begin
            pe_d = 1'b1;
`endif
          end else if (!valid_q || data_out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error   = pe_q;
`else
  assign parity_error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and random frame stimulus for uart_rx_frame, checked against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int unsigned BIT = 434;   // 8680 ns at a 20 ns clock

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, stable_viol = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;

  uart_rx_frame dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .parity_error  (parity_error)
  );

  always #10 clk = ~clk;

  // Observer: collects accepted bytes, counts pulse cycles, watches data_out stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid && data_out_ready) got.push_back(data_out);
      if (framing_error) fe_cnt++;
      if (overrun) pe_cnt = pe_cnt;
      if (overrun) ov_cnt++;
      if (parity_error) pe_cnt++;
      if (hold && data_out !== hold_data) stable_viol++;
      hold      = data_out_valid && !data_out_ready;
      hold_data = data_out;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    cycles(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) drive_bit(1'b1);
`endif
    drive_bit(stop_b);
  endtask

  // Reference: a well-formed frame delivers its byte when the consumer is ready.
  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
    exp_q.push_back(b);
  endtask

  task automatic clr_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
  endtask

  task automatic check_bytes(input string tag);
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag, input int fe, input int ov, input int pe);
    check({tag, "_framing"}, 32'(fe_cnt), 32'(fe));
    check({tag, "_overrun"}, 32'(ov_cnt), 32'(ov));
    check({tag, "_parity"}, 32'(pe_cnt), 32'(pe));
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] stim[4];
    stim[0] = 8'h78; stim[1] = 8'h79; stim[2] = 8'h7a; stim[3] = 8'h0d;

    rst_n = 1'b0;
    serial_in = 1'b1;
    data_out_ready = 1'b1;
    cycles(5);
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_out_valid), 32'h0);
    check("reset_flags", {29'h0, framing_error, overrun, parity_error}, 32'h0);
    rst_n = 1'b1;
    cycles(20);

    // Four bytes with ready held high
    clr_counts();
    for (int i = 0; i < 4; i++) begin
      send_good(stim[i]);
      cycles(20);
    end
    check_bytes("basic");
    check_flags("basic", 0, 0, 0);

    // Short low glitch is rejected, then a normal byte
    clr_counts();
    serial_in = 1'b0;
    cycles(100);
    serial_in = 1'b1;
    cycles(300);
    check("glitch_valid", 32'(got.size()), 32'h0);
    send_good(8'h31);
    cycles(20);
    check_bytes("glitch");
    check_flags("glitch", 0, 0, 0);

    // Stop bit low: framing error, byte dropped, receiver recovers
    clr_counts();
    send_frame(8'h55, 1'b0, 1'b0);
    serial_in = 1'b1;
    cycles(40);
    check("framing_nobyte", 32'(got.size()), 32'h0);
    check("framing_valid", 32'(data_out_valid), 32'h0);
    send_good(8'h35);
    cycles(20);
    check_bytes("framing");
    check_flags("framing", 1, 0, 0);

    // Consumer stalled: second byte overruns, first stays on data_out
    clr_counts();
    data_out_ready = 1'b0;
    send_frame(8'h31, 1'b1, 1'b0);
    cycles(20);
    send_frame(8'h35, 1'b1, 1'b0);
    cycles(20);
    check("ovr_data", 32'(data_out), 32'h31);
    check("ovr_valid", 32'(data_out_valid), 32'h1);
    check_flags("ovr", 0, 1, 0);
    data_out_ready = 1'b1;
    cycles(1);
    check("ovr_valid_drop", 32'(data_out_valid), 32'h0);
    exp_q.push_back(8'h31);
    check_bytes("ovr");

    // Back-to-back frames with no idle gap
    clr_counts();
    send_good(8'h0d);
    send_good(8'h0a);
    cycles(20);
    check_bytes("b2b");
    check_flags("b2b", 0, 0, 0);

    // Reset during data bit 3 of 0x3e aborts the frame
    clr_counts();
    b = 8'h3e;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    serial_in = b[3];
    cycles(BIT / 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(data_out), 32'h0);
    check("rst_mid_valid", 32'(data_out_valid), 32'h0);
    cycles(5);
    serial_in = 1'b1;
    rst_n = 1'b1;
    cycles(60);
    check("rst_mid_nobyte", 32'(got.size()), 32'h0);
    send_good(8'h20);
    cycles(20);
    check_bytes("rst_mid");
    check_flags("rst_mid", 0, 0, 0);

    // Random bytes
    clr_counts();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_good(b);
      cycles(10);
    end
    check_bytes("rand");
    check_flags("rand", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    clr_counts();
    send_good(8'h3e);
    cycles(20);
    check_bytes("par_ok");
    send_frame(8'h3e, 1'b1, 1'b1);
    cycles(20);
    check_bytes("par_bad");
    check_flags("par", 0, 0, 1);
`endif

    check("data_stable", 32'(stable_viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
On-chip UART receiver for the FPGA_SERIAL_RX line: 8N1, LSB first, idle-high line.
- Synchronizes the serial line, detects the start bit, and samples each bit at mid-period.
- Delivers each received byte over a valid/ready handshake to the CPU's memory-mapped UART register.
- Reports framing and overrun errors.

Parameters:
CLOCK_FREQ, 50_000_000, core clock frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s
SYNC_STAGES, 2, flops in the serial-input synchronizer (min 2)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
serial_in  input  1  asynchronous serial line, idle high
data_out  output  8  received byte
data_out_valid  output  1  byte available; held until accepted
data_out_ready  input  1  consumer accepts byte when high with valid
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because valid was still pending
parity_error  output  1  one-cycle pulse (UART_RX_PARITY_EN only; tied 0 otherwise)

Behaviour:
Constants:
- SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, integer division (434 at defaults).
- SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (217).
- Counter width = $clog2(SYMBOL_EDGE_TIME).

Reset (rst_n low, asynchronous):
- State IDLE, counters 0, synchronizer flops 1.
- data_out 0; data_out_valid, framing_error, overrun, parity_error all 0.

FSM (all decisions use the synchronized input rx_s):
- IDLE: on rx_s==0 -> START, clock counter cleared.
- START: at count SAMPLE_TIME-1, sample rx_s.
  - 1 -> IDLE (glitch rejected, no flags).
  - 0 -> DATA, bit index 0, counter cleared.
- DATA: every SYMBOL_EDGE_TIME cycles, shift rx_s into shift[bit index]. After index 7 -> STOP.
- STOP: after SYMBOL_EDGE_TIME cycles, sample rx_s.
  - 1: if valid==0 or ready==1, load data_out and set valid. Otherwise pulse overrun and keep the old data_out.
  - 0: pulse framing_error, byte discarded.
  - Either case -> IDLE the next cycle.
  - Re-arms mid-stop-bit, so back-to-back frames with no idle gap are received.

Handshake:
- valid clears on the cycle after valid && ready.
- Same-cycle byte completion and ready: the new byte is loaded and valid stays 1 (no overrun).

Latency:
- valid rises SYNC_STAGES + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles (±1) after serial_in falls.

Other rules:
- data_out is stable whenever valid==1.
- Reset mid-frame aborts the frame with no flags; the receiver returns to IDLE.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: one even-parity bit between data bit 7 and the stop bit.
  - Parity mismatch with a valid stop bit -> parity_error pulse, byte discarded.
  - Frame is 11 bits; latency adds SYMBOL_EDGE_TIME.
- Undefined: 8N1 only; parity_error driven constant 0.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP).
  - UART_DATA_BITS = 8.
  - Function computing SYMBOL_EDGE_TIME from CLOCK_FREQ/BAUD_RATE.
- Sub-module: synchronizer (SYNC_STAGES-deep, reset value 1), instantiated on serial_in.

Test Plan:
- Defaults, ready=1; send 0x78, 0x79, 0x7a, 0x0d (8N1, bit period 8680 ns) -> four valid pulses with data_out 0x78, 0x79, 0x7a, 0x0d; no error flags.
- serial_in low for 100 cycles, then high -> no valid, no framing_error; next byte 0x31 received correctly.
- Send 0x55 with stop bit driven 0 -> framing_error single pulse; valid stays 0; a following 0x35 is received correctly.
- ready=0; send 0x31 then 0x35 -> data_out=0x31, valid=1, overrun pulses once at the second stop sample. Raise ready -> valid drops the next cycle.
- Back-to-back 0x0d, 0x0a with no idle gap, ready=1 -> both bytes delivered in order.
- rst_n low for 5 cycles during data bit 3 of 0x3e -> outputs reset immediately; no valid or flags. A subsequent 0x20 is received correctly.
- UART_RX_PARITY_EN defined:
  - 0x3e with correct even parity -> valid.
  - 0x3e with wrong parity -> parity_error pulse, no valid.
